// File: rtl/pcie_ptile_rx_pkg.sv
// Shared route codes, TLP header match constants and error bit positions
// for the P-Tile RX TLP router.
package pcie_ptile_rx_pkg;

    localparam int NUM_PORTS = 3;

    typedef enum logic [1:0] {
        ROUTE_REQ = 2'd0,
        ROUTE_CPL = 2'd1,
        ROUTE_MSG = 2'd2
    } route_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FWD  = 1'b1
    } rx_state_e;

    // Compared against hdr[125:121]; bits [3:2] of that slice are hdr[124:123].
    localparam logic [4:0] CPL_FMT_TYPE     = 5'b00101;
    localparam logic [1:0] MSG_TYPE_HI      = 2'b10;
    localparam int         HDR_HAS_DATA_BIT = 126;

    localparam int ERR_WIDTH     = 4;
    localparam int ERR_ABORT_BIT = 0;

    function automatic route_e route_of(input logic [4:0] fmt_type);
        if (fmt_type == CPL_FMT_TYPE) return ROUTE_CPL;
        if (fmt_type[3:2] == MSG_TYPE_HI) return ROUTE_MSG;
        return ROUTE_REQ;
    endfunction

endpackage

// File: rtl/pcie_ptile_rx_fifo.sv
// Synchronous FIFO with occupancy output; a write while full is accepted
// only when a read frees a slot in the same cycle.
module pcie_ptile_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             wr_ok, rd_ok;

    assign count   = wr_ptr_q - rd_ptr_q;
    assign empty   = (count == '0);
    assign full    = (count == DEPTH_L);
    assign rd_data = mem[rd_ptr_q[AW-1:0]];

    always_comb begin
        rd_ok    = rd_en && !empty;
        wr_ok    = wr_en && (!full || rd_ok);
        wr_ptr_d = wr_ptr_q + (AW+1)'(wr_ok);
        rd_ptr_d = rd_ptr_q + (AW+1)'(rd_ok);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: storage is deliberately not reset; only the pointers define validity,
    // and leaving the array reset-free lets it map onto RAM.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr_q[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/pcie_ptile_rx_router.sv
// Buffers one P-Tile AVST RX segment and steers whole TLPs onto a shared
// output bus with one-hot request/completion/message valids and statistics.
module pcie_ptile_rx_router
    import pcie_ptile_rx_pkg::*;
#(
    parameter int SEG_DATA_WIDTH  = 256,
    parameter int SEG_EMPTY_WIDTH = $clog2(SEG_DATA_WIDTH/32),
    parameter int READY_LATENCY   = 27,
    parameter int FIFO_DEPTH      = 64,
    parameter int IO_BAR_INDEX    = 5,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [SEG_DATA_WIDTH-1:0]     rx_st_data,
    input  logic [SEG_EMPTY_WIDTH-1:0]    rx_st_empty,
    input  logic                          rx_st_sop,
    input  logic                          rx_st_eop,
    input  logic                          rx_st_valid,
    input  logic [127:0]                  rx_st_hdr,
    input  logic [2:0]                    rx_st_func_num,
    input  logic [2:0]                    rx_st_bar_range,
    input  logic                          rx_st_tlp_abort,
    output logic                          rx_st_ready,
    output logic [SEG_DATA_WIDTH-1:0]     out_tlp_data,
    output logic [SEG_DATA_WIDTH/32-1:0]  out_tlp_strb,
    output logic [127:0]                  out_tlp_hdr,
    output logic [2:0]                    out_tlp_bar_id,
    output logic [7:0]                    out_tlp_func_num,
    output logic [ERR_WIDTH-1:0]          out_tlp_error,
    output logic                          out_tlp_sop,
    output logic                          out_tlp_eop,
    output logic [NUM_PORTS-1:0]          out_tlp_valid,
    input  logic [NUM_PORTS-1:0]          out_tlp_ready,
    output logic [3*CNT_WIDTH-1:0]        stat_tlp_count,
    output logic [CNT_WIDTH-1:0]          stat_abort_count,
    output logic [CNT_WIDTH-1:0]          stat_drop_count,
    output logic                          stat_overflow,
    input  logic                          stat_clear
);

    localparam int STRB_W = SEG_DATA_WIDTH/32;
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_L   = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0] READY_THR = (AW+1)'(READY_LATENCY + 1);

    if (FIFO_DEPTH < 2*READY_LATENCY + 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two and at least 2*READY_LATENCY+4");
    end

    typedef struct packed {
        logic [SEG_DATA_WIDTH-1:0] data;
        logic [STRB_W-1:0]         strb;
        logic [127:0]              hdr;
        logic [2:0]                bar_id;
        logic [7:0]                func_num;
        logic                      sop;
        logic                      eop;
        logic                      abort;
    } entry_t;

    entry_t        wr_entry, head;
    logic          fifo_empty, fifo_full, pop;
    logic [AW:0]   fifo_count;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        wr_entry          = '0;
        wr_entry.data     = rx_st_data;
        wr_entry.hdr      = rx_st_hdr;
        wr_entry.func_num = {5'd0, rx_st_func_num};
        wr_entry.sop      = rx_st_sop;
        wr_entry.eop      = rx_st_eop;
        wr_entry.abort    = rx_st_tlp_abort;
        if (rx_st_sop && rx_st_eop && !rx_st_hdr[HDR_HAS_DATA_BIT]) wr_entry.strb = '0;
        else if (rx_st_eop) wr_entry.strb = {STRB_W{1'b1}} >> rx_st_empty;
        else wr_entry.strb = '1;
        case (rx_st_bar_range)
            3'd6:    wr_entry.bar_id = 3'(IO_BAR_INDEX);
            3'd7:    wr_entry.bar_id = 3'd6;
            default: wr_entry.bar_id = rx_st_bar_range;
        endcase
    end

    pcie_ptile_rx_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (rx_st_valid),
        .wr_data (wr_entry),
        .rd_en   (pop),
        .rd_data (head),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .count   (fifo_count)
    );

    rx_state_e                state_q, state_d;
    route_e                   route_q, route_d, out_route_q, out_route_d, load_route;
    logic [NUM_PORTS-1:0]     out_valid_q, out_valid_d;
    entry_t                   out_beat_q, out_beat_d;
    logic [ERR_WIDTH-1:0]     out_error_q, out_error_d;
    logic                     ready_q, ready_d, overflow_q, overflow_d;
    logic [CNT_WIDTH-1:0]     tlp_cnt_q [NUM_PORTS];
    logic [CNT_WIDTH-1:0]     tlp_cnt_d [NUM_PORTS];
    logic [CNT_WIDTH-1:0]     abort_cnt_q, abort_cnt_d, drop_cnt_q, drop_cnt_d;
    logic                     out_hs, load_ok, load, drop, eop_hs;

    assign out_hs  = |(out_valid_q & out_tlp_ready);
    assign load_ok = (out_valid_q == '0) || out_hs;
    assign eop_hs  = out_hs && out_beat_q.eop;

    always_comb begin
        state_d    = state_q;
        route_d    = route_q;
        load_route = route_q;
        pop        = 1'b0;
        load       = 1'b0;
        drop       = 1'b0;
        case (state_q)
            ST_IDLE: if (!fifo_empty) begin
                if (!head.sop) begin
                    // Orphan continuation beats (lost sop after overflow or reset) are discarded.
                    pop  = 1'b1;
                    drop = 1'b1;
                end else if (load_ok) begin
                    pop        = 1'b1;
                    load       = 1'b1;
                    load_route = route_of(head.hdr[125:121]);
                    route_d    = load_route;
                    state_d    = head.eop ? ST_IDLE : ST_FWD;
                end
            end
            ST_FWD: if (!fifo_empty && load_ok) begin
                pop  = 1'b1;
                load = 1'b1;
                if (head.eop) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        out_valid_d = out_hs ? '0 : out_valid_q;
        out_beat_d  = out_beat_q;
        out_error_d = out_error_q;
        out_route_d = out_route_q;
        if (load) begin
            out_valid_d                = 3'b001 << load_route;
            out_beat_d                 = head;
            out_route_d                = load_route;
            out_error_d                = '0;
            out_error_d[ERR_ABORT_BIT] = head.abort && head.eop;
        end

        ready_d    = (DEPTH_L - fifo_count) > READY_THR;
        overflow_d = overflow_q || (rx_st_valid && fifo_full && !pop);

        for (int r = 0; r < NUM_PORTS; r++) begin
            tlp_cnt_d[r] = tlp_cnt_q[r];
            if (eop_hs && int'(out_route_q) == r && tlp_cnt_q[r] != '1) tlp_cnt_d[r] = tlp_cnt_q[r] + 1'b1;
        end
        abort_cnt_d = abort_cnt_q;
        if (eop_hs && out_error_q[ERR_ABORT_BIT] && abort_cnt_q != '1) abort_cnt_d = abort_cnt_q + 1'b1;
        drop_cnt_d = drop_cnt_q;
        if (drop && drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + 1'b1;

        if (stat_clear) begin
            for (int r = 0; r < NUM_PORTS; r++) tlp_cnt_d[r] = '0;
            abort_cnt_d = '0;
            drop_cnt_d  = '0;
            overflow_d  = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            route_q     <= ROUTE_REQ;
            out_route_q <= ROUTE_REQ;
            out_valid_q <= '0;
            out_beat_q  <= '0;
            out_error_q <= '0;
            ready_q     <= 1'b0;
            overflow_q  <= 1'b0;
            tlp_cnt_q   <= '{default: '0};
            abort_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            route_q     <= route_d;
            out_route_q <= out_route_d;
            out_valid_q <= out_valid_d;
            out_beat_q  <= out_beat_d;
            out_error_q <= out_error_d;
            ready_q     <= ready_d;
            overflow_q  <= overflow_d;
            tlp_cnt_q   <= tlp_cnt_d;
            abort_cnt_q <= abort_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign rx_st_ready      = ready_q;
    assign out_tlp_valid    = out_valid_q;
    assign out_tlp_data     = out_beat_q.data;
    assign out_tlp_strb     = out_beat_q.strb;
    assign out_tlp_hdr      = out_beat_q.hdr;
    assign out_tlp_bar_id   = out_beat_q.bar_id;
    assign out_tlp_func_num = out_beat_q.func_num;
    assign out_tlp_sop      = out_beat_q.sop;
    assign out_tlp_eop      = out_beat_q.eop;
    assign out_tlp_error    = out_error_q;
    assign stat_tlp_count   = {tlp_cnt_q[2], tlp_cnt_q[1], tlp_cnt_q[0]};
    assign stat_abort_count = abort_cnt_q;
    assign stat_drop_count  = drop_cnt_q;
    assign stat_overflow    = overflow_q;

endmodule

// File: tb/tb_pcie_ptile_rx_router.sv
// Directed bench for pcie_ptile_rx_router: routing, strobes, back-pressure,
// abort flagging, overflow recovery, reset and statistics clear.
module tb_pcie_ptile_rx_router;

    localparam int RL       = 27;
    localparam int CAPACITY = 65; // 64 FIFO entries plus the output register

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [255:0] rx_st_data = '0;
    logic [2:0]   rx_st_empty = '0;
    logic         rx_st_sop = 1'b0, rx_st_eop = 1'b0, rx_st_valid = 1'b0;
    logic [127:0] rx_st_hdr = '0;
    logic [2:0]   rx_st_func_num = '0, rx_st_bar_range = '0;
    logic         rx_st_tlp_abort = 1'b0;
    logic         rx_st_ready;
    logic [255:0] out_tlp_data;
    logic [7:0]   out_tlp_strb;
    logic [127:0] out_tlp_hdr;
    logic [2:0]   out_tlp_bar_id;
    logic [7:0]   out_tlp_func_num;
    logic [3:0]   out_tlp_error;
    logic         out_tlp_sop, out_tlp_eop;
    logic [2:0]   out_tlp_valid;
    logic [2:0]   out_tlp_ready = '0;
    logic [47:0]  stat_tlp_count;
    logic [15:0]  stat_abort_count, stat_drop_count;
    logic         stat_overflow;
    logic         stat_clear = 1'b0;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        logic [2:0]   valid;
        logic [255:0] data;
        logic [7:0]   strb;
        logic [3:0]   err;
        logic         sop, eop;
        logic [2:0]   bar;
        logic [7:0]   func;
    } obs_t;
    obs_t obs_q[$];

    logic [127:0] hdr_mwr  = {8'h40, 24'h000008, 96'h0};
    logic [127:0] hdr_mwr3 = {8'h40, 24'h000018, 96'h0};
    logic [127:0] hdr_cpld = {8'h4A, 24'h00000D, 96'h0};
    logic [127:0] hdr_msg  = {8'h30, 24'h000000, 96'h0};
    logic [127:0] hdr_mrd  = {8'h00, 24'h000001, 96'h0};

    pcie_ptile_rx_router dut (
        .clk(clk), .rst_n(rst_n),
        .rx_st_data(rx_st_data), .rx_st_empty(rx_st_empty), .rx_st_sop(rx_st_sop),
        .rx_st_eop(rx_st_eop), .rx_st_valid(rx_st_valid), .rx_st_hdr(rx_st_hdr),
        .rx_st_func_num(rx_st_func_num), .rx_st_bar_range(rx_st_bar_range),
        .rx_st_tlp_abort(rx_st_tlp_abort), .rx_st_ready(rx_st_ready),
        .out_tlp_data(out_tlp_data), .out_tlp_strb(out_tlp_strb), .out_tlp_hdr(out_tlp_hdr),
        .out_tlp_bar_id(out_tlp_bar_id), .out_tlp_func_num(out_tlp_func_num),
        .out_tlp_error(out_tlp_error), .out_tlp_sop(out_tlp_sop), .out_tlp_eop(out_tlp_eop),
        .out_tlp_valid(out_tlp_valid), .out_tlp_ready(out_tlp_ready),
        .stat_tlp_count(stat_tlp_count), .stat_abort_count(stat_abort_count),
        .stat_drop_count(stat_drop_count), .stat_overflow(stat_overflow),
        .stat_clear(stat_clear)
    );

    always #5 clk = ~clk;

    // Record every output handshake; inputs change just after posedge, so negedge is stable.
    always @(negedge clk) begin
        if (rst_n && |(out_tlp_valid & out_tlp_ready))
            obs_q.push_back('{out_tlp_valid, out_tlp_data, out_tlp_strb, out_tlp_error,
                              out_tlp_sop, out_tlp_eop, out_tlp_bar_id, out_tlp_func_num});
    end

    task automatic send_beat(input logic [127:0] hdr, input logic [255:0] data,
                             input logic [2:0] empty, input logic sop, input logic eop,
                             input logic abort, input logic [2:0] bar, input logic [2:0] fn);
        @(posedge clk); #1;
        rx_st_hdr = hdr; rx_st_data = data; rx_st_empty = empty;
        rx_st_sop = sop; rx_st_eop = eop; rx_st_tlp_abort = abort;
        rx_st_bar_range = bar; rx_st_func_num = fn; rx_st_valid = 1'b1;
    endtask

    task automatic idle_in();
        @(posedge clk); #1;
        rx_st_valid = 1'b0; rx_st_sop = 1'b0; rx_st_eop = 1'b0; rx_st_tlp_abort = 1'b0;
    endtask

    task automatic wait_obs(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (obs_q.size() >= n) begin ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_assert++; if (rx_st_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got=%b exp=0", rx_st_ready); end
        n_assert++; if (out_tlp_valid !== 3'b000) begin n_fail++; $display("FAIL reset_valid got=%b exp=000", out_tlp_valid); end
        n_assert++; if ({stat_tlp_count, stat_abort_count, stat_drop_count, stat_overflow} !== '0) begin
            n_fail++; $display("FAIL reset_stats got=%h exp=0", {stat_tlp_count, stat_abort_count, stat_drop_count, stat_overflow}); end
        @(posedge clk); #1; rst_n = 1'b1;
        @(posedge clk); @(negedge clk);
        n_assert++; if (rx_st_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready got=%b exp=1", rx_st_ready); end
    endtask

    task automatic test_mwr_single();
        obs_q.delete();
        out_tlp_ready = 3'b111;
        send_beat(hdr_mwr, 256'h1111_2222_3333_4444_5555_6666_7777_8888, 3'd0, 1'b1, 1'b1, 1'b0, 3'd6, 3'd2);
        idle_in();
        @(negedge clk);
        n_assert++; if (out_tlp_valid !== 3'b000) begin n_fail++; $display("FAIL mwr_latency_n1 got=%b exp=000", out_tlp_valid); end
        @(negedge clk);
        n_assert++; if (out_tlp_valid !== 3'b001) begin n_fail++; $display("FAIL mwr_valid got=%b exp=001", out_tlp_valid); end
        n_assert++; if (out_tlp_strb !== 8'hFF) begin n_fail++; $display("FAIL mwr_strb got=%h exp=ff", out_tlp_strb); end
        n_assert++; if (out_tlp_data !== 256'h1111_2222_3333_4444_5555_6666_7777_8888) begin n_fail++; $display("FAIL mwr_data got=%h", out_tlp_data); end
        n_assert++; if ({out_tlp_bar_id, out_tlp_func_num} !== {3'd5, 8'd2}) begin
            n_fail++; $display("FAIL mwr_bar_func got=%0d/%0d exp=5/2", out_tlp_bar_id, out_tlp_func_num); end
        n_assert++; if ({out_tlp_sop, out_tlp_eop, out_tlp_error} !== 6'b11_0000) begin
            n_fail++; $display("FAIL mwr_flags got=%b exp=110000", {out_tlp_sop, out_tlp_eop, out_tlp_error}); end
        repeat (2) @(negedge clk);
        n_assert++; if (stat_tlp_count !== {16'd0, 16'd0, 16'd1}) begin n_fail++; $display("FAIL mwr_count got=%h exp=1 on port0", stat_tlp_count); end
    endtask

    task automatic test_cpld_two_beat();
        bit ok;
        obs_q.delete();
        send_beat(hdr_cpld, 256'hA1, 3'd0, 1'b1, 1'b0, 1'b0, 3'd7, 3'd7);
        send_beat(hdr_cpld, 256'hA2, 3'd5, 1'b0, 1'b1, 1'b0, 3'd7, 3'd7);
        idle_in();
        wait_obs(2, 20, ok);
        n_assert++; if (!ok) begin n_fail++; $display("FAIL cpld_timeout got=%0d beats exp=2", obs_q.size()); end
        if (ok) begin
            n_assert++; if (obs_q[0].valid !== 3'b010 || obs_q[1].valid !== 3'b010) begin
                n_fail++; $display("FAIL cpld_valid got=%b,%b exp=010", obs_q[0].valid, obs_q[1].valid); end
            n_assert++; if (obs_q[0].strb !== 8'hFF || obs_q[1].strb !== 8'h07) begin
                n_fail++; $display("FAIL cpld_strb got=%h,%h exp=ff,07", obs_q[0].strb, obs_q[1].strb); end
            n_assert++; if (obs_q[1].bar !== 3'd6 || obs_q[1].func !== 8'd7 || obs_q[1].eop !== 1'b1) begin
                n_fail++; $display("FAIL cpld_fields got=bar%0d func%0d eop%b exp=bar6 func7 eop1", obs_q[1].bar, obs_q[1].func, obs_q[1].eop); end
        end
        repeat (2) @(negedge clk);
        n_assert++; if (stat_tlp_count[31:16] !== 16'd1) begin n_fail++; $display("FAIL cpld_count got=%0d exp=1", stat_tlp_count[31:16]); end
    endtask

    task automatic test_msg_hol_block();
        bit ok;
        obs_q.delete();
        out_tlp_ready = 3'b011;
        send_beat(hdr_msg, 256'hBEEF, 3'd0, 1'b1, 1'b1, 1'b0, 3'd0, 3'd0);
        send_beat(hdr_mrd, 256'hCAFE, 3'd0, 1'b1, 1'b1, 1'b0, 3'd0, 3'd0);
        idle_in();
        repeat (10) @(negedge clk);
        n_assert++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL hol_no_handshake got=%0d exp=0", obs_q.size()); end
        n_assert++; if (out_tlp_valid !== 3'b100 || out_tlp_data !== 256'hBEEF) begin
            n_fail++; $display("FAIL hol_held got=%b/%h exp=100/beef", out_tlp_valid, out_tlp_data); end
        @(posedge clk); #1; out_tlp_ready = 3'b111;
        wait_obs(2, 20, ok);
        n_assert++; if (!ok) begin n_fail++; $display("FAIL hol_timeout got=%0d beats exp=2", obs_q.size()); end
        if (ok) begin
            n_assert++; if (obs_q[0].valid !== 3'b100 || obs_q[0].strb !== 8'h00) begin
                n_fail++; $display("FAIL hol_msg got=%b/%h exp=100/00", obs_q[0].valid, obs_q[0].strb); end
            n_assert++; if (obs_q[1].valid !== 3'b001 || obs_q[1].data !== 256'hCAFE) begin
                n_fail++; $display("FAIL hol_mrd got=%b/%h exp=001/cafe", obs_q[1].valid, obs_q[1].data); end
        end
        repeat (2) @(negedge clk);
        n_assert++; if (stat_tlp_count !== {16'd1, 16'd1, 16'd2}) begin n_fail++; $display("FAIL hol_counts got=%h exp=0001_0001_0002", stat_tlp_count); end
    endtask

    task automatic test_abort();
        bit ok;
        obs_q.delete();
        send_beat(hdr_mwr3, 256'hC1, 3'd0, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0);
        send_beat(hdr_mwr3, 256'hC2, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0);
        send_beat(hdr_mwr3, 256'hC3, 3'd0, 1'b0, 1'b1, 1'b1, 3'd0, 3'd0);
        idle_in();
        wait_obs(3, 20, ok);
        n_assert++; if (!ok) begin n_fail++; $display("FAIL abort_timeout got=%0d beats exp=3", obs_q.size()); end
        if (ok) begin
            n_assert++; if ({obs_q[0].err, obs_q[1].err, obs_q[2].err} !== 12'h001) begin
                n_fail++; $display("FAIL abort_err got=%h,%h,%h exp=0,0,1", obs_q[0].err, obs_q[1].err, obs_q[2].err); end
        end
        repeat (2) @(negedge clk);
        n_assert++; if (stat_abort_count !== 16'd1) begin n_fail++; $display("FAIL abort_count got=%0d exp=1", stat_abort_count); end
        n_assert++; if (stat_tlp_count[15:0] !== 16'd3) begin n_fail++; $display("FAIL abort_req_count got=%0d exp=3", stat_tlp_count[15:0]); end
    endtask

    task automatic test_overflow();
        int  total = 0, after_low = 0, bad = 0;
        bit  seen_low = 1'b0, sent_z = 1'b0, ok;
        obs_q.delete();
        out_tlp_ready = 3'b000;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (!rx_st_ready) seen_low = 1'b1;
            if (seen_low && after_low == RL) break;
            rx_st_hdr = hdr_mwr; rx_st_data = 256'(total); rx_st_empty = '0;
            rx_st_sop = 1'b1; rx_st_eop = 1'b1; rx_st_tlp_abort = 1'b0; rx_st_valid = 1'b1;
            total++;
            if (seen_low) after_low++;
        end
        rx_st_valid = 1'b0;
        @(negedge clk);
        n_assert++; if (stat_overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_latency_window got=%b exp=0 after %0d beats", stat_overflow, total); end
        for (int i = total; i < CAPACITY; i++) send_beat(hdr_mwr, 256'(i), 3'd0, 1'b1, 1'b1, 1'b0, 3'd0, 3'd0);
        send_beat(hdr_mwr, 256'hDEAD, 3'd0, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0);
        @(posedge clk); #1;
        out_tlp_ready = 3'b111;
        rx_st_data = 256'hD00D; rx_st_sop = 1'b0; rx_st_eop = 1'b1;
        @(negedge clk);
        n_assert++; if (stat_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got=%b exp=1", stat_overflow); end
        @(posedge clk); #1;
        out_tlp_ready = 3'b000; rx_st_valid = 1'b0; rx_st_eop = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_tlp_ready = 3'b111;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (rx_st_ready) begin sent_z = 1'b1; break; end
        end
        n_assert++; if (!sent_z) begin n_fail++; $display("FAIL ovf_ready_return got=0 exp=1"); end
        rx_st_hdr = hdr_cpld; rx_st_data = 256'hF00D; rx_st_empty = '0;
        rx_st_sop = 1'b1; rx_st_eop = 1'b1; rx_st_valid = sent_z;
        @(posedge clk); #1; rx_st_valid = 1'b0;
        wait_obs(CAPACITY + 1, 300, ok);
        n_assert++; if (!ok) begin n_fail++; $display("FAIL ovf_drain_timeout got=%0d beats exp=%0d", obs_q.size(), CAPACITY + 1); end
        if (ok) begin
            for (int i = 0; i < CAPACITY; i++)
                if (obs_q[i].valid !== 3'b001 || obs_q[i].data !== 256'(i)) bad++;
            n_assert++; if (bad != 0) begin n_fail++; $display("FAIL ovf_fillers got=%0d bad beats exp=0", bad); end
            n_assert++; if (obs_q[CAPACITY].valid !== 3'b010 || obs_q[CAPACITY].data !== 256'hF00D) begin
                n_fail++; $display("FAIL ovf_next_tlp got=%b/%h exp=010/f00d", obs_q[CAPACITY].valid, obs_q[CAPACITY].data); end
        end
        repeat (3) @(negedge clk);
        n_assert++; if (obs_q.size() != CAPACITY + 1) begin n_fail++; $display("FAIL ovf_beat_total got=%0d exp=%0d", obs_q.size(), CAPACITY + 1); end
        n_assert++; if (stat_drop_count !== 16'd1) begin n_fail++; $display("FAIL ovf_drop_count got=%0d exp=1", stat_drop_count); end
        n_assert++; if (stat_tlp_count !== {16'd1, 16'd2, 16'd68}) begin n_fail++; $display("FAIL ovf_counts got=%h exp=0001_0002_0044", stat_tlp_count); end
    endtask

    task automatic test_reset_mid_tlp_and_clear();
        bit ok, cleared = 1'b0;
        obs_q.delete();
        out_tlp_ready = 3'b111;
        send_beat(hdr_mwr3, 256'hE1, 3'd0, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0);
        idle_in();
        @(posedge clk); #1; rst_n = 1'b0;
        @(negedge clk);
        n_assert++; if ({rx_st_ready, out_tlp_valid} !== 4'b0000) begin n_fail++; $display("FAIL midrst_outputs got=%b exp=0000", {rx_st_ready, out_tlp_valid}); end
        n_assert++; if ({stat_tlp_count, stat_abort_count, stat_drop_count, stat_overflow} !== '0) begin
            n_fail++; $display("FAIL midrst_stats got=%h exp=0", {stat_tlp_count, stat_abort_count, stat_drop_count, stat_overflow}); end
        @(posedge clk); #1; rst_n = 1'b1;
        @(posedge clk); @(negedge clk);
        n_assert++; if (rx_st_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready got=%b exp=1", rx_st_ready); end
        send_beat(hdr_mwr3, 256'hE2, 3'd0, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0);
        idle_in();
        repeat (4) @(negedge clk);
        n_assert++; if (obs_q.size() != 0 || stat_drop_count !== 16'd1) begin
            n_fail++; $display("FAIL midrst_partial got=%0d beats drop=%0d exp=0 beats drop=1", obs_q.size(), stat_drop_count); end
        send_beat(hdr_mwr, 256'hE3, 3'd0, 1'b1, 1'b1, 1'b0, 3'd0, 3'd0);
        idle_in();
        wait_obs(1, 20, ok);
        repeat (2) @(negedge clk);
        n_assert++; if (stat_tlp_count[15:0] !== 16'd1) begin n_fail++; $display("FAIL clear_pre_count got=%0d exp=1", stat_tlp_count[15:0]); end
        send_beat(hdr_mwr, 256'hE4, 3'd0, 1'b1, 1'b1, 1'b0, 3'd0, 3'd0);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            rx_st_valid = 1'b0;
            if (out_tlp_valid != 3'b000) begin
                stat_clear = 1'b1;
                @(posedge clk); #1; stat_clear = 1'b0;
                cleared = 1'b1;
                break;
            end
        end
        @(negedge clk);
        n_assert++; if (!cleared || obs_q.size() != 2) begin n_fail++; $display("FAIL clear_handshake got=%0d beats exp=2", obs_q.size()); end
        n_assert++; if ({stat_tlp_count, stat_abort_count, stat_drop_count, stat_overflow} !== '0) begin
            n_fail++; $display("FAIL clear_priority got=%h exp=0", {stat_tlp_count, stat_abort_count, stat_drop_count, stat_overflow}); end
    endtask

    initial begin
        test_reset();
        test_mwr_single();
        test_cpld_two_beat();
        test_msg_hol_block();
        test_abort();
        test_overflow();
        test_reset_mid_tlp_and_clear();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pcie_ptile_rx_router.md
PCIE_PTILE_RX_ROUTER -- requirements
Module: pcie_ptile_rx_router

Interface
REQ-001 SHALL have parameter SEG_DATA_WIDTH, default 256, per-beat data width (128, 256 or 512).
REQ-002 SHALL have parameter SEG_EMPTY_WIDTH, default $clog2(SEG_DATA_WIDTH/32), dword-empty field width.
REQ-003 SHALL have parameter READY_LATENCY, default 27, cycles the source may keep sending after ready falls.
REQ-004 SHALL have parameter FIFO_DEPTH, default 64, beats, power of two, elaboration error if below 2*READY_LATENCY+4.
REQ-005 SHALL have parameters IO_BAR_INDEX (default 5) and CNT_WIDTH (default 16).
REQ-006 SHALL have clk  in  1  sole clock; reset is asynchronous and active-low.
REQ-007 SHALL have rst_n  in  1  asynchronous active-low reset.
REQ-008 SHALL have rx_st_data/empty/sop/eop/valid/hdr/func_num(3)/bar_range(3)/tlp_abort  in  P-Tile AVST, one segment.
REQ-009 SHALL have rx_st_ready  out  1  registered ready.
REQ-010 SHALL have out_tlp_data/strb/hdr(128)/bar_id(3)/func_num(8)/error(4)/sop/eop  out  shared TLP bus.
REQ-011 SHALL have out_tlp_valid  out  3  one-hot: bit0 request, bit1 completion, bit2 message.
REQ-012 SHALL have out_tlp_ready  in  3  per-port ready.
REQ-013 SHALL have stat_tlp_count  out  3*CNT_WIDTH, stat_abort_count and stat_drop_count  out  CNT_WIDTH each, stat_overflow  out  1, stat_clear  in  1.

Function
REQ-014 SHALL write every rx_st_valid beat into the FIFO regardless of rx_st_ready; entry = data, strb, hdr, bar_id, func_num, sop, eop, abort.
REQ-015 SHALL compute strb: all-ones; on eop, all-ones >> empty; on sop&eop with hdr[126]=0, zero.
REQ-016 SHALL map bar_range 6 -> IO_BAR_INDEX, 7 -> 6, else unchanged; func_num zero-extended 3 -> 8 bits.
REQ-017 SHALL register rx_st_ready <= free entries > READY_LATENCY+1.
REQ-018 SHALL, on write with FIFO full, discard the beat and set sticky stat_overflow.
REQ-019 SHALL run output FSM IDLE/FWD: IDLE with head sop latches route from head hdr, goes FWD; FWD beat with eop returns to IDLE.
REQ-020 SHALL route: hdr[125:121]=00101 -> completion; else hdr[124:123]=10 -> message; else request.
REQ-021 SHALL, in IDLE, pop a non-sop head beat without output, incrementing stat_drop_count (overflow recovery).
REQ-022 SHALL present head beat with out_tlp_valid[route]; pop on valid&ready of that port only; head-of-line blocking accepted.
REQ-023 SHALL hold out_tlp_* stable while valid and not ready.
REQ-024 SHALL set out_tlp_error[0] on the eop beat of a TLP whose eop input beat had tlp_abort; bits [3:1] zero.
REQ-025 SHALL have latency: beat accepted cycle N appears on output no earlier than N+2 with empty FIFO.
REQ-026 SHALL increment stat_tlp_count[route] at each output eop handshake, stat_abort_count when that beat has error[0].
REQ-027 SHALL saturate all counters at all-ones.
REQ-028 SHALL clear all counters and stat_overflow on stat_clear, clear taking priority over same-cycle increment.
REQ-029 SHALL support simultaneous FIFO write and pop when full (pop frees slot, write accepted).

Reset
REQ-030 SHALL, while rst_n=0, drive rx_st_ready, out_tlp_valid, all stats to 0, FSM IDLE, FIFO empty.
REQ-031 SHALL assert rx_st_ready on first clock edge after rst_n release; reset mid-TLP discards the partial TLP.

Structure
REQ-032 SHALL place route codes, fmt/type match constants and error bit positions in package pcie_ptile_rx_pkg.
REQ-033 SHALL use one sub-module pcie_ptile_rx_fifo: sync FIFO with occupancy output, async active-low reset.

Verification
REQ-034 SHALL test MWr 3DW, 8 dwords, 256-bit, empty=0 -> one beat on valid[0], strb=0xFF, stat_tlp_count[0]=1.
REQ-035 SHALL test CplD hdr[127:120]=0x4A, 2 beats, final empty=5 -> valid[1], strbs 0xFF then 0x07.
REQ-036 SHALL test Msg hdr[127:120]=0x30 followed by MRd with out_tlp_ready[2]=0 for 10 cycles -> MRd held, delivered after message.
REQ-037 SHALL test tlp_abort on eop of a 3-beat MWr -> error=0001 on beat 3 only, stat_abort_count=1.
REQ-038 SHALL test all ready low, source sends READY_LATENCY beats after ready drop -> no overflow; one extra beat past full -> stat_overflow=1, orphan beats dropped, next TLP intact.
REQ-039 SHALL test rst_n pulsed mid-TLP and stat_clear with a same-cycle eop -> outputs zero, counters zero.
